fifo_wr_arbiter: RTL

Round-robin scheduler that shares the single write port of the 8-entry, 32-bit FIFO between up to N_REQ producers. It tracks FIFO occupancy internally with a credit counter, so it never issues a write into a full FIFO and never depends on a lagging FULL flag. It drives the FIFO's WR/dataIn pair from registers and returns a same-cycle acknowledge to the winning producer. It sits between the producer blocks and the FIFO write side; the consumer reports each pop back through rd_ack.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO write-side arbiter and its FIFO.
// Bursting is compiled in only when FIFO_ARB_BURST_EN is defined (see fifo_wr_arbiter).
package fifo_arb_pkg;

   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_DW    = 32;
   localparam int MAX_REQ    = 8;

   // Wide enough for any supported producer count; ports narrow it to clog2(N_REQ).
   typedef logic [$clog2(MAX_REQ)-1:0] gnt_idx_t;

   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first asserted req at or after start wins.
// Shared with the planned read-side scheduler, so it stays free of arbiter state.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  gnt_idx_t     start,
   output logic         valid,
   output logic [N-1:0] gnt,
   output gnt_idx_t     idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] pos;

   // Scan offsets from farthest to nearest so the nearest hit is the last one written.
   always_comb begin
      valid = 1'b0;
      gnt   = '0;
      idx   = '0;
      pos   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = IW'((int'(start) + k) % N);
         if (req[pos]) begin
            valid    = 1'b1;
            gnt      = '0;
            gnt[pos] = 1'b1;
            idx      = gnt_idx_t'(pos);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-tracked scheduler for the single FIFO write port.
// Define FIFO_ARB_BURST_EN to let a winner keep the port for up to BURST_LEN grants.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DW        = FIFO_DW,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int BURST_LEN = 4
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*DW-1:0]           data,
   output logic [N_REQ-1:0]              ack,
   input  logic                          rd_ack,
   output logic                          fifo_wr,
   output logic [DW-1:0]                 fifo_din,
   output logic [$clog2(N_REQ)-1:0]      gnt_id,
   output logic [credit_w(DEPTH)-1:0]    credits,
   output logic                          ovf_err
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = credit_w(DEPTH);
   localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);

   logic [DW-1:0]    word [N_REQ];
   logic             fifo_wr_reg;
   logic [DW-1:0]    fifo_din_reg;
   logic [IW-1:0]    gnt_id_reg;
   logic [CW-1:0]    credits_reg;
   logic             ovf_err_reg;
   gnt_idx_t         last_gnt_reg;
   gnt_idx_t         start;
   gnt_idx_t         pick_idx;
   gnt_idx_t         winner;
   logic             pick_valid;
   logic [N_REQ-1:0] pick_onehot;
   logic             has_credit;
   logic             keep;
   logic             grant;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_word
         assign word[gi] = data[gi*DW +: DW];
      end
   endgenerate

   assign start = (last_gnt_reg == gnt_idx_t'(N_REQ - 1)) ? '0 : last_gnt_reg + gnt_idx_t'(1);

   rr_pick #(.N(N_REQ)) u_pick (
      .req   (req),
      .start (start),
      .valid (pick_valid),
      .gnt   (pick_onehot),
      .idx   (pick_idx)
   );

   // A pop in the same cycle frees the slot this write needs, so zero credits is not a stall then.
   assign has_credit = (credits_reg != '0) || rd_ack;
   assign winner     = keep ? last_gnt_reg : pick_idx;
   assign grant      = !Rst && has_credit && (keep || pick_valid);

   always_comb begin
      ack = '0;
      if (grant) begin
         if (keep) begin
            ack[last_gnt_reg[IW-1:0]] = 1'b1;
         end else begin
            ack = pick_onehot;
         end
      end
   end

`ifdef FIFO_ARB_BURST_EN
   localparam int BW = $clog2(BURST_LEN + 1);

   logic [BW-1:0] burst_cnt_reg;

   // Zero count means no burst is open, so the reset-time last_gnt never holds the port.
   assign keep = (burst_cnt_reg != '0) && (burst_cnt_reg < BW'(BURST_LEN))
                 && req[last_gnt_reg[IW-1:0]];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         burst_cnt_reg <= '0;
      end else if (grant) begin
         burst_cnt_reg <= keep ? burst_cnt_reg + BW'(1) : BW'(1);
      end else if (!req[last_gnt_reg[IW-1:0]]) begin
         burst_cnt_reg <= '0;
      end
   end
`else
   // Bursts are compiled out; BURST_LEN only matters with FIFO_ARB_BURST_EN.
   assign keep = (BURST_LEN < 0);
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         fifo_wr_reg  <= 1'b0;
         fifo_din_reg <= '0;
         gnt_id_reg   <= '0;
         credits_reg  <= FULL_CREDITS;
         ovf_err_reg  <= 1'b0;
         last_gnt_reg <= gnt_idx_t'(N_REQ - 1);
      end else begin
         fifo_wr_reg <= grant;
         if (grant) begin
            fifo_din_reg <= word[winner[IW-1:0]];
            gnt_id_reg   <= winner[IW-1:0];
            last_gnt_reg <= winner;
         end
         if (grant && !rd_ack) begin
            credits_reg <= credits_reg - CW'(1);
         end else if (rd_ack && !grant && credits_reg != FULL_CREDITS) begin
            credits_reg <= credits_reg + CW'(1);
         end
         if (rd_ack && credits_reg == FULL_CREDITS) begin
            ovf_err_reg <= 1'b1;
         end
      end
   end

   assign fifo_wr  = fifo_wr_reg;
   assign fifo_din = fifo_din_reg;
   assign gnt_id   = gnt_id_reg;
   assign credits  = credits_reg;
   assign ovf_err  = ovf_err_reg;

endmodule
